game_state_ctl: RTL

- Upstream game-flow controller. Produces the g_state value that drives the per-screen VGA selection stage (START / LEVEL_1 / FINISH).
- Decides transitions from mouse clicks, player positions and the level button status.
- Applies every state change only at a frame boundary (vblnk rising edge), so the selected screen never switches mid-frame.
- Also issues a one-cycle level_start pulse used to re-initialise player and rectangle controllers.

---
 rtl/game_state_ctl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/game_state_ctl.sv
// Game-flow controller that feeds the per-screen VGA selection stage.
// State changes are applied only on a frame boundary (vblnk rising edge),
// so the selected screen never switches mid-frame.
//
// Ports:
//   clk            pixel clock
//   rst            asynchronous reset, active-high
//   vblnk          vertical blank; its rising edge is the frame boundary
//   mouse_left     left mouse button level, already synchronous to clk
//   xpos_mouse     mouse x
//   ypos_mouse     mouse y
//   xpos_player1   player 1 x position
//   xpos_player2   player 2 x position
//   button_pressed level buttons held (bit0 player 1, bit1 player 2)
//   game_state     current state: 0 = START, 1 = LEVEL_1, 2 = FINISH
//   level_start    one-cycle pulse when game_state becomes LEVEL_1
//   hold_cnt       consecutive exit-hold frame count
module game_state_ctl #(
  parameter int unsigned BTN_X0        = 412,
  parameter int unsigned BTN_X1        = 611,
  parameter int unsigned BTN_Y0        = 334,
  parameter int unsigned BTN_Y1        = 433,
  parameter int unsigned EXIT_X        = 900,
  parameter int unsigned HOLD_FRAMES   = 30,
  parameter int unsigned FINISH_FRAMES = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] xpos_mouse,
  input  logic [11:0] ypos_mouse,
  input  logic [11:0] xpos_player1,
  input  logic [11:0] xpos_player2,
  input  logic [1:0]  button_pressed,
  output logic [1:0]  game_state,
  output logic        level_start,
  output logic [5:0]  hold_cnt
);

  localparam int unsigned FcW = (FINISH_FRAMES > 1) ? $clog2(FINISH_FRAMES) : 1;

  localparam logic [11:0]    BtnX0    = 12'(BTN_X0);
  localparam logic [11:0]    BtnX1    = 12'(BTN_X1);
  localparam logic [11:0]    BtnY0    = 12'(BTN_Y0);
  localparam logic [11:0]    BtnY1    = 12'(BTN_Y1);
  localparam logic [11:0]    ExitX    = 12'(EXIT_X);
  localparam logic [5:0]     HoldLast = 6'(HOLD_FRAMES - 1);
  localparam logic [FcW-1:0] FcLast   = FcW'(FINISH_FRAMES - 1);

  typedef enum logic [1:0] {
    StStart  = 2'd0,
    StLevel1 = 2'd1,
    StFinish = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     hold_q, hold_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic           pend_q, pend_d;
  logic           ls_q, ls_d;
  logic           vblnk_q, mouse_q;

  logic frame_tick, click, in_btn, exit_ok;

  assign frame_tick = vblnk & ~vblnk_q;
  assign click      = mouse_left & ~mouse_q;
  assign in_btn     = (xpos_mouse >= BtnX0) && (xpos_mouse <= BtnX1) &&
                      (ypos_mouse >= BtnY0) && (ypos_mouse <= BtnY1);
  assign exit_ok    = (xpos_player1 >= ExitX) && (xpos_player2 >= ExitX) &&
                      (button_pressed == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StStart;
      hold_q  <= '0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      ls_q    <= 1'b0;
      vblnk_q <= 1'b0;
      mouse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      ls_q    <= ls_d;
      vblnk_q <= vblnk;
      mouse_q <= mouse_left;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    ls_d    = 1'b0;

    // A click only pends; it is acted on at the next frame tick at the earliest.
    if (click) begin
      if ((state_q == StStart && in_btn) || state_q == StFinish) begin
        pend_d = 1'b1;
      end
    end

    if (frame_tick) begin
      case (state_q)
        StStart: begin
          if (pend_q) begin
            state_d = StLevel1;
            hold_d  = '0;
            ls_d    = 1'b1;
          end
        end
        StLevel1: begin
          if (exit_ok) begin
            if (hold_q == HoldLast) begin
              state_d = StFinish;
              hold_d  = '0;
              fcnt_d  = '0;
            end else if (hold_q != 6'h3f) begin
              hold_d = hold_q + 6'd1;
            end
          end else begin
            hold_d = '0;
          end
        end
        StFinish: begin
          if (pend_q || fcnt_q == FcLast) begin
            state_d = StStart;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StStart;
          hold_d  = '0;
          fcnt_d  = '0;
        end
      endcase
    end

    // Any state change discards a pending click, including one seen this cycle.
    if (state_d != state_q) begin
      pend_d = 1'b0;
    end
  end

  assign game_state  = state_q;
  assign level_start = ls_q;
  assign hold_cnt    = hold_q;

endmodule
